dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Parametrised data-memory controller for the MEM stage. It replaces the fixed 4 KB byte memory with a configurable-depth word-organised array behind a valid/ready request port. Misaligned halfword and word accesses are either split into two back-to-back word accesses or rejected with an error flag, selected by parameter. Byte-lane writes and sign/zero-extended loads are carried over from the current memory.

## Interface
- ADDR_W, 12, byte-address width; array is 2^ADDR_W bytes (2^(ADDR_W-2) 32-bit words).
- SPLIT_MISALIGN, 1, 1 = split misaligned accesses into two word accesses; 0 = reject with rsp_misalign.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts a request this cycle; equals (state==IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  single-cycle response pulse, loads and stores alike; no backpressure.
- rsp_rdata  out  32  extended load data; 0 for stores and rejected accesses.
- rsp_misalign  out  1  access was misaligned and rejected (SPLIT_MISALIGN=0 only).

## Operation
- Accept = req_valid && req_ready. W = req_addr[ADDR_W-1:2], off = req_addr[1:0].
- Misaligned: half with off[0]=1; word with off!=0. Bytes never misaligned.
- FSM states: IDLE, SECOND.
  - IDLE, accept aligned: one word access at W, go IDLE (stays ready).
  - IDLE, accept misaligned, SPLIT_MISALIGN=1: first access at W, latch request, go SECOND.
  - IDLE, accept misaligned, SPLIT_MISALIGN=0: no array access, no write; response with rsp_misalign=1, rsp_rdata=0; stay IDLE.
  - SECOND: access at W+1 modulo 2^(ADDR_W-2) (top word wraps to word 0), go IDLE.
- Store lanes: form 64-bit lane mask = size mask (0x01/0x03/0x0F) << off and data = req_wdata << (8*off); low 4 mask bits/32 data bits go to word W, high 4 to word W+1. Aligned stores use only the low half.
- Load: read word W (and W+1 when split) into a 64-bit buffer {hi, lo}; shift right by 8*off; take low 8/16/32 bits; extend per req_unsigned (word ignores it).
- Array is not reset; contents undefined until written.
- Read-during-write same word: a load accepted the cycle after a store sees the stored data; there is no same-cycle conflict (one access per cycle).

## Timing
- Reset values: state IDLE, req_ready 1 in the cycle after rst deasserts (0 while rst high), rsp_valid 0, rsp_rdata 0, rsp_misalign 0.
- Aligned or rejected access accepted at edge N: rsp_valid high for cycle N+1 only.
- Split access accepted at edge N: req_ready low during cycle N+1, second access at edge N+1, rsp_valid in cycle N+2. Back-to-back issue: next request accepted at edge N+2 earliest.
- Split store: low lanes written at edge N, high lanes at edge N+1.
- Aligned sustained throughput: one request per cycle, responses one cycle behind.
- rst asserted in SECOND: split aborted, high lanes of a split store NOT written (low lanes remain), no response issued.
- Requests presented while rst is high are ignored.

## Test plan
- SW 0xDEADBEEF @0x010, then LW @0x010 on the next cycle -> rsp_rdata 0xDEADBEEF one cycle after the load accept, req_ready held 1.
- SB 0x80 @0x013, then LB @0x013 -> 0xFFFFFF80; LBU @0x013 -> 0x00000080; LH @0x012 -> sign-extended 0x80xx with the byte at 0x012 below it.
- SPLIT=1: SW 0x11223344 @0x00E, LW @0x00E -> 0x11223344, req_ready low one cycle, rsp two cycles after accept; LW @0x00C shows 0x3344 in [31:16].
- SPLIT=1, ADDR_W=12: SH 0xA55A @0xFFF -> byte 0xFFF=0x5A, byte 0x000=0xA5 (wrap); LHU @0xFFF -> 0x0000A55A.
- SPLIT=0: SW @0x021 -> rsp_misalign 1, rsp_rdata 0, subsequent LW @0x020 shows prior contents unchanged.
- SPLIT=1: SW 0xFFFFFFFF @0x031 over zeroed memory, rst asserted in SECOND -> no rsp; LW @0x030 = 0xFFFFFF00, LW @0x034 = 0x00000000.

Source files
------------

// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between the MEM stage and dmem_ctrl.
interface dmem_ctrl_if #(parameter int ADDR_W = 12);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_misalign;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_misalign
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_misalign
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Word-organised data memory with byte-lane stores, extended loads and
// optional splitting of misaligned accesses into two word accesses.
//
// state  | meaning
// IDLE   | ready; aligned and rejected accesses complete here
// SECOND | second word (W+1) of a split misaligned access
module dmem_ctrl #(
  parameter int ADDR_W         = 12,
  parameter bit SPLIT_MISALIGN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  dmem_ctrl_if.slave bus
);
  localparam int WA_W = ADDR_W - 2;

  typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_t;

  state_t state, state_nxt;

  logic [31:0] mem [1 << WA_W];

  logic              lat_we, lat_unsigned;
  logic [1:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata, lat_lo;

  logic              accept, misalign, latch_en;
  logic              cur_we, cur_unsigned;
  logic [1:0]        cur_size, cur_off;
  logic [WA_W-1:0]   cur_word;
  logic [31:0]       cur_wdata;
  logic [3:0]        size_mask;
  logic [7:0]        mask8;
  logic [63:0]       data64, rd64;
  logic [31:0]       rd_word, rd_shift, load_val;

  logic              mem_we;
  logic [3:0]        mem_mask;
  logic [31:0]       mem_wdata;

  logic              rsp_valid_q, rsp_mis_q, rsp_valid_nxt, rsp_mis_nxt;
  logic [31:0]       rsp_rdata_q, rsp_rdata_nxt;

  assign bus.req_ready    = (state == IDLE) && !rst;
  assign accept           = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.rsp_misalign = rsp_mis_q;

  // In SECOND every lane/shift decision comes from the latched request.
  always_comb begin
    if (state == SECOND) begin
      cur_we       = lat_we;
      cur_unsigned = lat_unsigned;
      cur_size     = lat_size;
      cur_off      = lat_addr[1:0];
      cur_word     = lat_addr[ADDR_W-1:2] + WA_W'(1);
      cur_wdata    = lat_wdata;
    end else begin
      cur_we       = bus.req_we;
      cur_unsigned = bus.req_unsigned;
      cur_size     = bus.req_size;
      cur_off      = bus.req_addr[1:0];
      cur_word     = bus.req_addr[ADDR_W-1:2];
      cur_wdata    = bus.req_wdata;
    end
  end

  always_comb begin
    case (cur_size)
      2'b00:   size_mask = 4'h1;
      2'b01:   size_mask = 4'h3;
      default: size_mask = 4'hF;
    endcase
  end

  assign misalign = ((cur_size == 2'b01) && cur_off[0]) || (cur_size[1] && (cur_off != 2'b00));
  assign mask8    = {4'h0, size_mask} << cur_off;
  assign data64   = {32'h0, cur_wdata} << {cur_off, 3'b000};
  assign rd_word  = mem[cur_word];
  assign rd64     = (state == SECOND) ? {rd_word, lat_lo} : {32'h0, rd_word};
  assign rd_shift = 32'(rd64 >> {cur_off, 3'b000});

  always_comb begin
    case (cur_size)
      2'b00:   load_val = cur_unsigned ? {24'h0, rd_shift[7:0]}
                                       : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_val = cur_unsigned ? {16'h0, rd_shift[15:0]}
                                       : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: load_val = rd_shift;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    mem_we        = 1'b0;
    mem_mask      = 4'h0;
    mem_wdata     = data64[31:0];
    latch_en      = 1'b0;
    rsp_valid_nxt = 1'b0;
    rsp_mis_nxt   = 1'b0;
    rsp_rdata_nxt = 32'h0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!misalign) begin
            mem_we        = cur_we;
            mem_mask      = mask8[3:0];
            rsp_valid_nxt = 1'b1;
            rsp_rdata_nxt = cur_we ? 32'h0 : load_val;
          end else if (SPLIT_MISALIGN) begin
            mem_we    = cur_we;
            mem_mask  = mask8[3:0];
            latch_en  = 1'b1;
            state_nxt = SECOND;
          end else begin
            rsp_valid_nxt = 1'b1;
            rsp_mis_nxt   = 1'b1;
          end
        end
      end
      SECOND: begin
        mem_we        = cur_we;
        mem_mask      = mask8[7:4];
        mem_wdata     = data64[63:32];
        rsp_valid_nxt = 1'b1;
        rsp_rdata_nxt = cur_we ? 32'h0 : load_val;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_mis_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state       <= state_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_mis_q   <= rsp_mis_nxt;
      rsp_rdata_q <= rsp_rdata_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (latch_en) begin
      lat_we       <= bus.req_we;
      lat_unsigned <= bus.req_unsigned;
      lat_size     <= bus.req_size;
      lat_addr     <= bus.req_addr;
      lat_wdata    <= bus.req_wdata;
      lat_lo       <= rd_word;
    end
  end

  // Reset in SECOND suppresses the high-lane write of a split store.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_mask[i]) mem[cur_word][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: a splitting and a rejecting instance share one stimulus
// stream and are checked every cycle against byte-array models.
module tb_dmem_ctrl;
  localparam int AW = 12;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    bit          mis;
    bit          pin_en;
    logic [31:0] pin;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [AW-1:0] req_addr = '0;
  logic [31:0] req_wdata = 32'h0;

  always #5 clk = ~clk;

  dmem_ctrl_if #(.ADDR_W(AW)) bus1 ();
  dmem_ctrl_if #(.ADDR_W(AW)) bus0 ();

  assign bus1.req_valid = req_valid;    assign bus0.req_valid = req_valid;
  assign bus1.req_we = req_we;          assign bus0.req_we = req_we;
  assign bus1.req_size = req_size;      assign bus0.req_size = req_size;
  assign bus1.req_unsigned = req_unsigned; assign bus0.req_unsigned = req_unsigned;
  assign bus1.req_addr = req_addr;      assign bus0.req_addr = req_addr;
  assign bus1.req_wdata = req_wdata;    assign bus0.req_wdata = req_wdata;

  dmem_ctrl #(.ADDR_W(AW), .SPLIT_MISALIGN(1'b1)) u_split  (.clk(clk), .rst(rst), .bus(bus1));
  dmem_ctrl #(.ADDR_W(AW), .SPLIT_MISALIGN(1'b0)) u_reject (.clk(clk), .rst(rst), .bus(bus0));

  logic [7:0]  mm [2][4096];
  exp_t        q0[$], q1[$];
  int          cyc = 0;
  int          busy1 = -10;
  int          n_vec = 0, n_err = 0;
  bit          pin_en [2];
  logic [31:0] pin_val [2];

  task automatic tick();
    @(posedge clk);
    cyc = cyc + 1;
  endtask

  task automatic cmp(string name, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  function automatic bit is_mis(logic [1:0] size, logic [AW-1:0] addr);
    return ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
  endfunction

  // Behavioural effect of one accepted request on instance d (1 = split, 0 = reject).
  task automatic model(int d, bit we, logic [1:0] size, bit uns, logic [AW-1:0] addr,
                       logic [31:0] wdata, bit abort);
    int nb, off;
    bit mis;
    exp_t e;
    logic [31:0] v;
    nb  = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    off = int'(addr[1:0]);
    mis = is_mis(size, addr);
    e.due = cyc + ((mis && d == 1) ? 1 : 0);
    e.rdata = 32'h0; e.mis = 1'b0; e.pin_en = pin_en[d]; e.pin = pin_val[d];
    if (d == 0 && mis) begin
      e.mis = 1'b1;
    end else if (we) begin
      for (int i = 0; i < nb; i++)
        if (!(abort && mis && off + i >= 4)) mm[d][(int'(addr) + i) % 4096] = wdata[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = mm[d][(int'(addr) + i) % 4096];
      if (nb == 1 && !uns && v[7])  v = v | 32'hFFFF_FF00;
      if (nb == 2 && !uns && v[15]) v = v | 32'hFFFF_0000;
      e.rdata = v;
    end
    if (d == 1 && mis) busy1 = cyc;
    if (!(abort && mis)) begin
      if (d == 1) q1.push_back(e); else q0.push_back(e);
    end
  endtask

  task automatic issue(bit we, logic [1:0] size, bit uns, logic [AW-1:0] addr,
                       logic [31:0] wdata, bit abort = 1'b0);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    tick();
    model(1, we, size, uns, addr, wdata, abort);
    model(0, we, size, uns, addr, wdata, 1'b0);
    pin_en[0] = 1'b0; pin_en[1] = 1'b0;
    #1 req_valid = 1'b0;
    if (is_mis(size, addr)) begin
      if (abort) begin
        // reset lands on the second-access edge; the request shown now must be ignored
        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
        req_addr = 12'h034; req_wdata = 32'h1234_5678;
      end
      tick();
      #1 rst = 1'b0; req_valid = 1'b0;
    end
  endtask

  task automatic pin(bit en1, logic [31:0] v1, bit en0, logic [31:0] v0);
    pin_en[1] = en1; pin_val[1] = v1;
    pin_en[0] = en0; pin_val[0] = v0;
  endtask

  task automatic check_dut(int d, logic rdy, logic rv, logic [31:0] rd, logic rm);
    exp_t e;
    bit have, rdy_exp;
    string tag;
    tag = (d == 1) ? "split" : "reject";
    rdy_exp = !rst && !(d == 1 && cyc == busy1);
    cmp({"ready_", tag}, 32'(rdy), 32'(rdy_exp));
    have = 1'b0;
    if (d == 1 && q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); have = 1'b1; end
    if (d == 0 && q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); have = 1'b1; end
    cmp({"rsp_valid_", tag}, 32'(rv), 32'(have));
    if (have) begin
      cmp({"rsp_rdata_", tag}, rd, e.rdata);
      cmp({"rsp_misalign_", tag}, 32'(rm), 32'(e.mis));
      if (e.pin_en) cmp({"pinned_", tag}, rd, e.pin);
    end
  endtask

  always @(negedge clk) begin
    check_dut(1, bus1.req_ready, bus1.rsp_valid, bus1.rsp_rdata, bus1.rsp_misalign);
    check_dut(0, bus0.req_ready, bus0.rsp_valid, bus0.rsp_rdata, bus0.rsp_misalign);
  end

  initial begin
    int r;
    logic [AW-1:0] a;
    repeat (3) tick();
    #1 rst = 1'b0;
    cmp("reset_rdata_split", bus1.rsp_rdata, 32'h0);
    cmp("reset_mis_split", 32'(bus1.rsp_misalign), 32'h0);
    cmp("reset_rdata_reject", bus0.rsp_rdata, 32'h0);
    cmp("reset_mis_reject", 32'(bus0.rsp_misalign), 32'h0);

    for (int i = 0; i < 1024; i++) issue(1'b1, 2'b10, 1'b0, AW'(i * 4), 32'h0);

    issue(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEAD_BEEF);
    pin(1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF); issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    issue(1'b1, 2'b00, 1'b0, 12'h013, 32'h0000_0080);
    pin(1, 32'hFFFF_FF80, 1, 32'hFFFF_FF80); issue(1'b0, 2'b00, 1'b0, 12'h013, 32'h0);
    pin(1, 32'h0000_0080, 1, 32'h0000_0080); issue(1'b0, 2'b00, 1'b1, 12'h013, 32'h0);
    pin(1, 32'hFFFF_80AD, 1, 32'hFFFF_80AD); issue(1'b0, 2'b01, 1'b0, 12'h012, 32'h0);

    issue(1'b1, 2'b10, 1'b0, 12'h00E, 32'h1122_3344);
    pin(1, 32'h1122_3344, 0, 32'h0); issue(1'b0, 2'b10, 1'b0, 12'h00E, 32'h0);
    pin(1, 32'h3344_0000, 1, 32'h0); issue(1'b0, 2'b10, 1'b0, 12'h00C, 32'h0);

    issue(1'b1, 2'b01, 1'b0, 12'hFFF, 32'h0000_A55A);
    pin(1, 32'h0000_A55A, 0, 32'h0); issue(1'b0, 2'b01, 1'b1, 12'hFFF, 32'h0);
    pin(1, 32'h0000_00A5, 1, 32'h0); issue(1'b0, 2'b00, 1'b1, 12'h000, 32'h0);

    issue(1'b1, 2'b10, 1'b0, 12'h021, 32'hCAFE_F00D);
    pin(1, 32'hFEF0_0D00, 1, 32'h0); issue(1'b0, 2'b10, 1'b0, 12'h020, 32'h0);

    issue(1'b1, 2'b10, 1'b0, 12'h031, 32'hFFFF_FFFF, 1'b1);
    pin(1, 32'hFFFF_FF00, 1, 32'h0); issue(1'b0, 2'b10, 1'b0, 12'h030, 32'h0);
    pin(1, 32'h0, 1, 32'h0);         issue(1'b0, 2'b10, 1'b0, 12'h034, 32'h0);

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        tick();
        #1;
      end else begin
        r = int'($urandom_range(0, 3));
        if (r == 0)      a = AW'($urandom);
        else if (r == 1) a = AW'(12'hFF8 + $urandom_range(0, 7));
        else             a = AW'(12'h040 + $urandom_range(0, 31));
        issue(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
      end
    end

    repeat (4) begin tick(); #1; end
    cmp("drain_split", 32'(q1.size()), 32'h0);
    cmp("drain_reject", 32'(q0.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
